// File: rtl/cpu_mul_hi_seq.sv
// Multi-cycle 32x32 multiply (low word, or high word unsigned/mixed/signed) built on one registered 16x16 multiplier.
// Latency 6 cycles from the start-sampling edge to done; start is ignored (not queued) while busy.
module cpu_mul_hi_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_CORR,
    S_DONE
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        w_capture;

  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [1:0]  r_op;
  logic [1:0]  r_k;
  logic [1:0]  r_mk;
  logic        r_mvld;
  logic [31:0] r_mul;
  logic [63:0] r_acc;
  logic [31:0] r_result;

  logic [15:0] w_ma;
  logic [15:0] w_mb;
  logic [31:0] w_prod;
  logic [63:0] w_pp;
  logic [31:0] w_hi;
  logic [31:0] w_res;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_capture = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_capture = 1'b1;
          w_next    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (r_k == 2'd3) begin
          w_next = S_DRAIN;
        end
      end
      S_DRAIN: w_next = S_CORR;
      S_CORR:  w_next = S_DONE;
      S_DONE: begin
        if (start) begin
          w_capture = 1'b1;
          w_next    = S_ISSUE;
        end else begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // k bit 0 picks the upper half of a, bit 1 the upper half of b.
  assign w_ma   = r_k[0] ? r_a[31:16] : r_a[15:0];
  assign w_mb   = r_k[1] ? r_b[31:16] : r_b[15:0];
  assign w_prod = {16'd0, w_ma} * {16'd0, w_mb};

  always_comb begin
    w_pp = 64'd0;
    case (r_mk)
      2'd0:    w_pp = {32'd0, r_mul};
      2'd1:    w_pp = {16'd0, r_mul, 16'd0};
      2'd2:    w_pp = {16'd0, r_mul, 16'd0};
      default: w_pp = {r_mul, 32'd0};
    endcase
  end

  // Signed high words come from the unsigned high word minus the sign-bit weighted operands.
  assign w_hi = r_acc[63:32];
  always_comb begin
    w_res = 32'd0;
    case (r_op)
      2'b00:   w_res = r_acc[31:0];
      2'b01:   w_res = w_hi;
      2'b10:   w_res = w_hi - (r_a[31] ? r_b : 32'd0);
      default: w_res = w_hi - (r_a[31] ? r_b : 32'd0) - (r_b[31] ? r_a : 32'd0);
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a      <= 32'd0;
      r_b      <= 32'd0;
      r_op     <= 2'd0;
      r_k      <= 2'd0;
      r_mk     <= 2'd0;
      r_mvld   <= 1'b0;
      r_mul    <= 32'd0;
      r_acc    <= 64'd0;
      r_result <= 32'd0;
    end else begin
      r_mvld <= (r_state == S_ISSUE);
      r_mk   <= r_k;
      if (r_state == S_ISSUE) begin
        r_mul <= w_prod;
        r_k   <= r_k + 2'd1;
      end
      if (w_capture) begin
        r_a   <= src1;
        r_b   <= src2;
        r_op  <= op;
        r_k   <= 2'd0;
        r_acc <= 64'd0;
      end else if (r_mvld) begin
        r_acc <= r_acc + w_pp;
      end
      if (r_state == S_CORR) begin
        r_result <= w_res;
      end
    end
  end

  assign busy   = (r_state == S_ISSUE) || (r_state == S_DRAIN) || (r_state == S_CORR);
  assign done   = (r_state == S_DONE);
  assign result = r_result;

endmodule

// File: tb/tb_cpu_mul_hi_seq.sv
// Scoreboard bench for cpu_mul_hi_seq: driver pushes expected words, a negedge monitor pops on done.
module tb_cpu_mul_hi_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [31:0] src1 = 32'd0;
  logic [31:0] src2 = 32'd0;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  logic [31:0] q_res[$];
  int          q_e0[$];
  logic [31:0] last_res = 32'd0;

  cpu_mul_hi_seq dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .src1   (src1),
    .src2   (src2),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] ref_model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint     sa;
    longint     sb;
    logic [63:0] p;
    sa = o[1] ? longint'($signed(a)) : longint'({32'd0, a});
    sb = (o == 2'b11) ? longint'($signed(b)) : longint'({32'd0, b});
    p  = sa * sb;
    return (o == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      last_res = 32'd0;
    end else begin
      chk("busy_done_excl", {31'd0, busy & done}, 32'd0);
      if (done) begin
        if (q_res.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done got=%h exp=no_done at t=%0t", result, $time);
        end else begin
          logic [31:0] e;
          int e0;
          e  = q_res.pop_front();
          e0 = q_e0.pop_front();
          chk("result", result, e);
          chk("latency", 32'(cyc - e0), 32'd6);
        end
        last_res = result;
      end else begin
        chk("result_hold", result, last_res);
      end
    end
  end

  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    int n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      total++;
      bad++;
      $display("FAIL issue_timeout got=busy exp=idle at t=%0t", $time);
      return;
    end
    op    = o;
    src1  = a;
    src2  = b;
    start = 1'b1;
    q_res.push_back(exp);
    q_e0.push_back(cyc + 1);
    @(negedge clk);
    start = 1'b0;
    op    = 2'($urandom);
    src1  = $urandom;
    src2  = $urandom;
  endtask

  task automatic drain();
    int n = 0;
    while (q_res.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (q_res.size() != 0) begin
      bad++;
      $display("FAIL drain_timeout got=%0d exp=0 pending", q_res.size());
      q_res.delete();
      q_e0.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] b;

    repeat (2) @(negedge clk);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_result", result, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    issue(2'b00, 32'h00010003, 32'h00020005, 32'h000B000F);
    issue(2'b01, 32'h00010003, 32'h00020005, 32'h00000002);
    issue(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
    issue(2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000);
    issue(2'b10, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF);
    issue(2'b11, 32'h80000000, 32'h80000000, 32'h40000000);
    drain();

    // start during a busy operation must be dropped
    issue(2'b00, 32'h12345678, 32'h9ABCDEF0, ref_model(2'b00, 32'h12345678, 32'h9ABCDEF0));
    @(negedge clk);
    op    = 2'b01;
    src1  = 32'hFFFFFFFF;
    src2  = 32'hFFFFFFFF;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain();
    repeat (10) @(negedge clk);

    // back-to-back capture in the DONE cycle
    issue(2'b11, 32'hDEADBEEF, 32'h0BADF00D, ref_model(2'b11, 32'hDEADBEEF, 32'h0BADF00D));
    issue(2'b10, 32'hCAFEBABE, 32'h87654321, ref_model(2'b10, 32'hCAFEBABE, 32'h87654321));
    drain();

    // asynchronous abort mid-operation
    issue(2'b11, 32'hF0F0F0F0, 32'h13579BDF, 32'h0);
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_result", result, 32'd0);
    q_res.delete();
    q_e0.delete();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    issue(2'b11, 32'hF0F0F0F0, 32'h13579BDF, ref_model(2'b11, 32'hF0F0F0F0, 32'h13579BDF));
    drain();

    for (int i = 0; i < 1000; i++) begin
      case ($urandom_range(0, 7))
        0:       a = 32'd0;
        1:       a = 32'hFFFFFFFF;
        2:       a = 32'h80000000;
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1:       b = 32'hFFFFFFFF;
        2:       b = 32'h80000000;
        default: b = $urandom;
      endcase
      for (int o = 0; o < 4; o++) begin
        issue(2'(o), a, b, ref_model(2'(o), a, b));
      end
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
